bnn_xnor_popcount_acc: RTL and testbench
========================================

Name: bnn_xnor_popcount_acc

Overview:
Downstream consumer of the image-read address sequencer. It takes the image words the memory returns for each asserted read enable, XNORs each word with a weight word, and popcounts the result. It accumulates the popcounts over one frame of NWORDS words, then emits the frame sum and a binarized activation bit, qualified by a one-cycle valid pulse.

Parameters:
DW, 32, image/weight word width in bits
NWORDS, 20, words per frame; matches the sequencer address range 0..19
RD_LAT, 1, memory read latency in cycles from read enable to data valid
PW, 6, popcount width; must satisfy PW >= clog2(DW+1)
SW, 10, accumulator/sum width; must satisfy SW >= clog2(NWORDS*DW+1); no saturation logic

Ports:
iCLK  in  1  clock; all state updates on rising edge
iRSTn  in  1  asynchronous, active-low reset
iCLR  in  1  synchronous clear; same behaviour as reset, applied on the clock edge
iRd_EN  in  1  read enable issued to the image memory by the upstream sequencer
iDATA  in  DW  image word from memory; valid RD_LAT cycles after iRd_EN
iWEIGHT  in  DW  weight word; must be presented in the same cycle as the matching iDATA
iTHRESH  in  SW  activation threshold; sampled on the ACC->DONE transition
oSUM  out  SW  frame XNOR-popcount sum; held until the next DONE
oBIT  out  1  activation bit, (sum >= iTHRESH); held until the next DONE
oVALID  out  1  one-cycle pulse while in DONE
oBUSY  out  1  high in ACC, or while any pipeline valid bit is set

Behaviour:
- Reset or iCLR:
  - state=IDLE; acc, word count, delay line, pc_reg and pc_vld all 0
  - oSUM=0, oBIT=0, oVALID=0, oBUSY=0
  - iCLR has priority over every other event in that cycle.
- Data-valid alignment: a shift register of depth RD_LAT delays iRd_EN to produce dvld.
- Stage 1: when dvld=1, pc_reg <= popcount(~(iDATA ^ iWEIGHT)) and pc_vld <= 1; otherwise pc_vld <= 0.
- Stage 2 (accumulate), applied when pc_vld=1:
  - acc <= acc + pc_reg and cnt <= cnt + 1.
  - In the DONE state, acc <= pc_reg and cnt <= 1 instead, so a new frame starts cleanly.
- FSM states:
  - IDLE: go to ACC when pc_vld=1; the accumulate happens on that same edge.
  - ACC: go to DONE on the edge where the accumulation brings cnt to NWORDS. On that edge, oSUM <= final acc and oBIT <= (final acc >= iTHRESH), using the unsigned compare.
  - DONE: oVALID=1 for exactly one cycle; acc and cnt clear. Go to IDLE, or to ACC if pc_vld=1 in this cycle (first word of the next frame).
- Latency: oVALID is high RD_LAT+2 cycles after the cycle holding the last iRd_EN of the frame (3 cycles at default).
- Gaps: gaps in iRd_EN between words are allowed; the accumulator holds its value while pc_vld=0. There is no timeout.
- Extra words: words beyond NWORDS are counted into the next frame.
- Reset mid-frame: the partial frame is discarded and no oVALID is produced. The next frame starts from zero.
- Width: pc_reg is zero-extended to SW before the add; the add is unsigned modulo 2^SW, which the parameter constraint makes unreachable.

Decomposition:
- Shared package bnn_pkg holds:
  - the state encoding constants IDLE_ST=2'd0, ACC_ST=2'd1, DONE_ST=2'd2
  - the DW, NWORDS and derived PW/SW defaults, shared with the address sequencer.
- One sub-module: bnn_popcount (combinational adder tree, DW in, PW out), instantiated in stage 1.

Test Plan:
1. Reset: assert iRSTn=0 mid-frame after 7 words -> all outputs 0 immediately. After release, a full frame produces the correct sum, with no leftover from the 7 words.
2. All match, iDATA=iWEIGHT=32'hFFFFFFFF for 20 consecutive iRd_EN cycles, iTHRESH=320 -> one oVALID pulse 3 cycles after the last iRd_EN, oSUM=640, oBIT=1.
3. All mismatch, iDATA=32'hFFFFFFFF, iWEIGHT=0:
   - iTHRESH=1 -> oSUM=0, oBIT=0
   - repeat with iTHRESH=0 -> oBIT=1
4. Half match, iDATA=32'h0000FFFF, iWEIGHT=32'hFFFFFFFF -> oSUM=320. iTHRESH=320 -> oBIT=1; iTHRESH=321 -> oBIT=0.
5. iCLR pulse after 10 words -> no oVALID and oBUSY=0 next cycle. The following 20-word all-match frame gives oSUM=640.
6. Gapped and back-to-back frames:
   - iRd_EN with a 3-cycle gap after every 4th word -> same oSUM=640.
   - A second frame whose first data is valid in the DONE cycle -> second oVALID with the correct independent sum (e.g. 320 for the half-match pattern).

Source files
------------

// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared widths and FSM encoding for the BNN image datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    localparam int BNN_DW     = 32;
    localparam int BNN_NWORDS = 20;
    localparam int BNN_RD_LAT = 1;
    localparam int BNN_PW     = $clog2(BNN_DW + 1);
    localparam int BNN_SW     = $clog2(BNN_NWORDS * BNN_DW + 1);

    typedef enum logic [1:0] {
        IDLE_ST = 2'd0,
        ACC_ST  = 2'd1,
        DONE_ST = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bnn_popcount.sv
`default_nettype none
// ============================================================================
// Module      : bnn_popcount
// Description : Combinational balanced adder-tree population count.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int DW = BNN_DW,
    parameter int PW = BNN_PW
) (
    input  logic [DW-1:0] bits,
    output logic [PW-1:0] count
);

    localparam int LVLS = (DW > 1) ? $clog2(DW) : 0;
    localparam int NP   = 1 << LVLS;

    // Heap-ordered tree: leaves at NP-1.., node i sums children 2i+1 and 2i+2.
    logic [PW-1:0] tree [2*NP-1];

    always_comb begin
        for (int i = 0; i < 2*NP-1; i++) begin
            tree[i] = '0;
        end
        for (int i = 0; i < DW; i++) begin
            tree[NP-1+i] = PW'(bits[i]);
        end
        for (int i = NP-2; i >= 0; i--) begin
            tree[i] = tree[2*i+1] + tree[2*i+2];
        end
        count = tree[0];
    end

endmodule
`default_nettype wire

// File: rtl/bnn_xnor_popcount_acc.sv
`default_nettype none
// ============================================================================
// Module      : bnn_xnor_popcount_acc
// Description : XNOR-popcount accumulator over one frame, with binarized output.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_xnor_popcount_acc
    import bnn_pkg::*;
#(
    parameter int DW     = BNN_DW,
    parameter int NWORDS = BNN_NWORDS,
    parameter int RD_LAT = BNN_RD_LAT,
    parameter int PW     = BNN_PW,
    parameter int SW     = BNN_SW
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iRd_EN,
    input  logic [DW-1:0] iDATA,
    input  logic [DW-1:0] iWEIGHT,
    input  logic [SW-1:0] iTHRESH,
    output logic [SW-1:0] oSUM,
    output logic          oBIT,
    output logic          oVALID,
    output logic          oBUSY
);

    localparam int            CW       = $clog2(NWORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS);

    logic [RD_LAT-1:0] dly;
    logic              dvld;
    logic [DW-1:0]     xnor_word;
    logic [PW-1:0]     pc_comb;
    logic [PW-1:0]     pc_reg;
    logic              pc_vld;

    state_e            state;
    state_e            state_nxt;
    logic [SW-1:0]     acc;
    logic [SW-1:0]     acc_nxt;
    logic [SW-1:0]     acc_base;
    logic [SW-1:0]     acc_sum;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     cnt_base;
    logic [CW-1:0]     cnt_inc;
    logic              load_out;
    logic [SW-1:0]     sum_q;
    logic              bit_q;

    // Read-enable delay line aligns the enable with the returned memory word.
    generate
        if (RD_LAT == 1) begin : g_dly_one
            always_ff @(posedge iCLK or negedge iRSTn) begin
                if (!iRSTn) begin
                    dly <= '0;
                end else if (iCLR) begin
                    dly <= '0;
                end else begin
                    dly <= iRd_EN;
                end
            end
        end else begin : g_dly_multi
            always_ff @(posedge iCLK or negedge iRSTn) begin
                if (!iRSTn) begin
                    dly <= '0;
                end else if (iCLR) begin
                    dly <= '0;
                end else begin
                    dly <= {dly[RD_LAT-2:0], iRd_EN};
                end
            end
        end
    endgenerate

    assign dvld      = dly[RD_LAT-1];
    assign xnor_word = ~(iDATA ^ iWEIGHT);

    bnn_popcount #(
        .DW (DW),
        .PW (PW)
    ) u_popcount (
        .bits  (xnor_word),
        .count (pc_comb)
    );

    // DONE restarts from zero so a word arriving in that cycle opens a fresh frame.
    always_comb begin
        acc_base  = (state == DONE_ST) ? '0 : acc;
        cnt_base  = (state == DONE_ST) ? '0 : cnt;
        acc_sum   = acc_base + SW'(pc_reg);
        cnt_inc   = cnt_base + CW'(1);

        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        load_out  = 1'b0;

        case (state)
            IDLE_ST, ACC_ST, DONE_ST: begin
                if (state == DONE_ST) begin
                    state_nxt = IDLE_ST;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
                if (pc_vld) begin
                    if (cnt_inc == LAST_CNT) begin
                        state_nxt = DONE_ST;
                        load_out  = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ACC_ST;
                        acc_nxt   = acc_sum;
                        cnt_nxt   = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE_ST;
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            pc_reg <= '0;
            pc_vld <= 1'b0;
            state  <= IDLE_ST;
            acc    <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            bit_q  <= 1'b0;
        end else if (iCLR) begin
            pc_reg <= '0;
            pc_vld <= 1'b0;
            state  <= IDLE_ST;
            acc    <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            bit_q  <= 1'b0;
        end else begin
            pc_vld <= dvld;
            if (dvld) begin
                pc_reg <= pc_comb;
            end
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            if (load_out) begin
                sum_q <= acc_sum;
                bit_q <= (acc_sum >= iTHRESH);
            end
        end
    end

    assign oSUM   = sum_q;
    assign oBIT   = bit_q;
    assign oVALID = (state == DONE_ST);
    assign oBUSY  = (state == ACC_ST) | (|dly) | pc_vld;

endmodule
`default_nettype wire

// File: tb/tb_bnn_xnor_popcount_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_xnor_popcount_acc
// Description : Scoreboard bench for the XNOR-popcount frame accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_xnor_popcount_acc;

    localparam int NW = 20;

    logic        iCLK;
    logic        iRSTn;
    logic        iCLR;
    logic        iRd_EN;
    logic [31:0] iDATA;
    logic [31:0] iWEIGHT;
    logic [9:0]  iTHRESH;
    logic [9:0]  oSUM;
    logic        oBIT;
    logic        oVALID;
    logic        oBUSY;

    bnn_xnor_popcount_acc dut (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .iCLR    (iCLR),
        .iRd_EN  (iRd_EN),
        .iDATA   (iDATA),
        .iWEIGHT (iWEIGHT),
        .iTHRESH (iTHRESH),
        .oSUM    (oSUM),
        .oBIT    (oBIT),
        .oVALID  (oVALID),
        .oBUSY   (oBUSY)
    );

    typedef struct {
        int sum;
        int b;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_cnt = 0;
    int   m_acc = 0;
    int   m_cnt = 0;
    int   last_sum = 0;

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Reference: a frame is simply the sum of per-word matching-bit counts.
    task automatic model_issue(input logic [31:0] d, input logic [31:0] w);
        exp_t e;
        m_acc += $countones(~(d ^ w));
        m_cnt++;
        if (m_cnt == NW) begin
            e.sum = m_acc;
            e.b   = (m_acc >= int'(iTHRESH)) ? 1 : 0;
            e.cyc = cyc_cnt + 3;
            exp_q.push_back(e);
            last_sum = m_acc;
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
    endtask

    // One cycle: raise the enable now, present its word in the following cycle.
    task automatic step(input logic en, input logic [31:0] d, input logic [31:0] w);
        iRd_EN = en;
        if (en) model_issue(d, w);
        @(posedge iCLK);
        #1;
        iRd_EN  = 1'b0;
        iDATA   = en ? d : $urandom;
        iWEIGHT = en ? w : $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
    endtask

    task automatic frame(input logic [31:0] d, input logic [31:0] w, input int gap_every);
        for (int i = 0; i < NW; i++) begin
            step(1'b1, d, w);
            if (gap_every > 0 && (i % gap_every) == gap_every - 1 && i != NW - 1) idle(3);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            idle(1);
            n++;
        end
        idle(2);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_sum_held"}, int'(oSUM), last_sum);
    endtask

    always @(negedge iCLK) begin
        exp_t e;
        if (oVALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sum", int'(oSUM), e.sum);
                check("bit", int'(oBIT), e.b);
                check("valid_latency", cyc_cnt, e.cyc);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rw;
        iRSTn   = 1'b0;
        iCLR    = 1'b0;
        iRd_EN  = 1'b0;
        iDATA   = '0;
        iWEIGHT = '0;
        iTHRESH = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_sum", int'(oSUM), 0);
        check("rst_bit", int'(oBIT), 0);
        check("rst_valid", int'(oVALID), 0);
        check("rst_busy", int'(oBUSY), 0);
        iRSTn = 1'b1;
        idle(2);

        iTHRESH = 10'd320;
        frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_drain("all_match");

        for (int i = 0; i < 7; i++) step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        iRSTn = 1'b0;
        #1;
        check("async_rst_sum", int'(oSUM), 0);
        check("async_rst_bit", int'(oBIT), 0);
        check("async_rst_valid", int'(oVALID), 0);
        check("async_rst_busy", int'(oBUSY), 0);
        model_reset();
        last_sum = 0;
        @(posedge iCLK);
        #1;
        iRSTn = 1'b1;
        idle(2);
        frame(32'h0000_FFFF, 32'hFFFF_FFFF, 0);
        wait_drain("after_reset");

        iTHRESH = 10'd1;
        frame(32'hFFFF_FFFF, 32'h0, 0);
        wait_drain("mismatch_t1");
        iTHRESH = 10'd0;
        frame(32'hFFFF_FFFF, 32'h0, 0);
        wait_drain("mismatch_t0");

        iTHRESH = 10'd320;
        frame(32'h0000_FFFF, 32'hFFFF_FFFF, 0);
        wait_drain("half_t320");
        iTHRESH = 10'd321;
        frame(32'h0000_FFFF, 32'hFFFF_FFFF, 0);
        wait_drain("half_t321");

        iTHRESH = 10'd320;
        for (int i = 0; i < 10; i++) step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        iCLR = 1'b1;
        @(posedge iCLK);
        #1;
        iCLR = 1'b0;
        model_reset();
        last_sum = 0;
        check("clr_busy", int'(oBUSY), 0);
        check("clr_valid", int'(oVALID), 0);
        check("clr_sum", int'(oSUM), 0);
        idle(2);
        frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_drain("after_clr");

        frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
        wait_drain("gapped");

        frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        frame(32'h0000_FFFF, 32'hFFFF_FFFF, 0);
        wait_drain("back_to_back");

        for (int f = 0; f < 10; f++) begin
            if (f % 3 != 2) begin
                wait_drain("rand_gap");
                iTHRESH = 10'($urandom_range(0, 640));
            end
            for (int i = 0; i < NW; i++) begin
                rd = $urandom;
                rw = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    rw = rd ^ (32'h1 << $urandom_range(0, 31));
                end
                step(1'b1, rd, rw);
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
